bmem_arbiter: RTL and testbench

- Sole owner of the burst-memory (bmem) port; shares it between instruction-cache and data-cache line requests.
- Converts 256-bit line reads/writes into 64-bit bmem beats and back. Replaces the ad-hoc bmem_read/bmem_write sequencing in the fetch logic and the stand-alone deserializer.
- Sits between the caches' dfp ports and the cpu's bmem ports; one transaction in flight at a time.

---
 rtl/bmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_bmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// Shares the burst-memory port between I-cache and D-cache line requests,
// splitting 256-bit lines into 64-bit beats and reassembling read beats.
module bmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4,
   parameter int LINE_W = DATA_W * BEATS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_dfp_addr,
   input  logic              i_dfp_read,
   output logic [LINE_W-1:0] i_dfp_rdata,
   output logic              i_dfp_resp,
   input  logic [ADDR_W-1:0] d_dfp_addr,
   input  logic              d_dfp_read,
   input  logic              d_dfp_write,
   input  logic [LINE_W-1:0] d_dfp_wdata,
   output logic [LINE_W-1:0] d_dfp_rdata,
   output logic              d_dfp_resp,
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [DATA_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [ADDR_W-1:0] bmem_raddr,
   input  logic [DATA_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_CMD   = 3'd1;
   localparam logic [2:0] RD_DATA  = 3'd2;
   localparam logic [2:0] WR_BURST = 3'd3;
   localparam logic [2:0] RESP     = 3'd4;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   logic [2:0]                   state_q, state_d;
   logic                         gnt_q, gnt_d;
   logic                         last_q, last_d;
   logic [ADDR_W-1:0]            addr_q, addr_d;
   logic [BEATS-1:0][DATA_W-1:0] wdata_q, wdata_d;
   logic [BEATS-1:0][DATA_W-1:0] i_line_q, i_line_d;
   logic [BEATS-1:0][DATA_W-1:0] d_line_q, d_line_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         wr_go_q, wr_go_d;
   logic                         i_req, d_req, pick_d, beat_ok, wr_beat;

   always_comb begin
      i_req   = i_dfp_read;
      d_req   = d_dfp_read | d_dfp_write;
      // On a tie the port that did not win last time gets the grant.
      pick_d  = d_req & (~i_req | (last_q == GNT_I));
      beat_ok = (state_q == RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);
      // Once the write burst starts it runs back-to-back regardless of ready.
      wr_beat = (state_q == WR_BURST) && (wr_go_q || bmem_ready);

      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      i_line_d = i_line_q;
      d_line_d = d_line_q;
      cnt_d    = cnt_q;
      wr_go_d  = wr_go_q;

      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               gnt_d  = pick_d;
               last_d = pick_d;
               if (pick_d) addr_d = {d_dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               else        addr_d = {i_dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               // Writeback is served before the refill when both are pending.
               if (pick_d && d_dfp_write) begin
                  wdata_d = d_dfp_wdata;
                  state_d = WR_BURST;
               end else begin
                  state_d = RD_CMD;
               end
            end
         end
         RD_CMD: begin
            if (bmem_ready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (beat_ok) begin
               if (gnt_q == GNT_D) d_line_d[cnt_q] = bmem_rdata;
               else                i_line_d[cnt_q] = bmem_rdata;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = RESP;
               end
            end
         end
         WR_BURST: begin
            if (wr_beat) begin
               wr_go_d = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  wr_go_d = 1'b0;
                  state_d = RESP;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= GNT_I;
         last_q   <= GNT_D;
         addr_q   <= '0;
         wdata_q  <= '0;
         i_line_q <= '0;
         d_line_q <= '0;
         cnt_q    <= '0;
         wr_go_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         i_line_q <= i_line_d;
         d_line_q <= d_line_d;
         cnt_q    <= cnt_d;
         wr_go_q  <= wr_go_d;
      end
   end

   assign bmem_addr   = addr_q;
   assign bmem_read   = (state_q == RD_CMD);
   assign bmem_write  = wr_beat;
   assign bmem_wdata  = wr_beat ? wdata_q[cnt_q] : '0;
   assign i_dfp_resp  = (state_q == RESP) && (gnt_q == GNT_I);
   assign d_dfp_resp  = (state_q == RESP) && (gnt_q == GNT_D);
   assign i_dfp_rdata = i_line_q;
   assign d_dfp_rdata = d_line_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: a small bmem responder plus a scoreboard of
// expected line transactions checked as each completion pulse appears.
module tb_bmem_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int BEATS  = 4;
   localparam int LINE_W = 256;
   localparam int BUDGET = 200;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] i_dfp_addr;
   logic              i_dfp_read;
   logic [LINE_W-1:0] i_dfp_rdata;
   logic              i_dfp_resp;
   logic [ADDR_W-1:0] d_dfp_addr;
   logic              d_dfp_read;
   logic              d_dfp_write;
   logic [LINE_W-1:0] d_dfp_wdata;
   logic [LINE_W-1:0] d_dfp_rdata;
   logic              d_dfp_resp;
   logic [ADDR_W-1:0] bmem_addr;
   logic              bmem_read;
   logic              bmem_write;
   logic [DATA_W-1:0] bmem_wdata;
   logic              bmem_ready;
   logic [ADDR_W-1:0] bmem_raddr;
   logic [DATA_W-1:0] bmem_rdata;
   logic              bmem_rvalid;

   bmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
      .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
      .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
      .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   // kind: 0 = I read, 1 = D read, 2 = D write
   typedef struct {
      int               kind;
      logic [LINE_W-1:0] line;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] wq[$];
   int                vectors = 0;
   int                miscompares = 0;
   int                rd_hi = 0;
   int                rd_cmds = 0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] beat_base = 64'hA;
   bit                addr_tag = 1'b0;
   bit                inject_bad = 1'b0;

   function automatic logic [DATA_W-1:0] beat_val(logic [ADDR_W-1:0] a, int k);
      return beat_base + DATA_W'(k) + (addr_tag ? {a, 32'h0} : 64'h0);
   endfunction

   function automatic logic [LINE_W-1:0] mk_line(logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] l;
      for (int k = 0; k < BEATS; k++) l[DATA_W*k +: DATA_W] = beat_val(a, k);
      return l;
   endfunction

   task automatic check(string tag, logic [LINE_W-1:0] obs, logic [LINE_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bus monitor: command/beat activity sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (bmem_read) rd_hi++;
         if (bmem_read && bmem_ready) begin
            rd_cmds++;
            cmd_addr = bmem_addr;
         end
         if (bmem_write) begin
            wq.push_back(bmem_wdata);
            wr_addr = bmem_addr;
         end
      end
   end

   // bmem read responder; optionally emits a stray beat before acceptance and a
   // foreign-address beat before the real burst.
   initial begin
      logic [ADDR_W-1:0] a;
      bmem_rvalid = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (bmem_read && bmem_ready) begin
            a = bmem_addr;
            if (inject_bad) begin
               bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
               @(negedge clk);
               bmem_raddr = 32'hDEAD_0000; bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            end
            @(negedge clk);
            for (int k = 0; k < BEATS; k++) begin
               bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = beat_val(a, k);
               @(negedge clk);
            end
            bmem_rvalid = 1'b0;
         end
      end
   end

   task automatic finish_txn(string tag, output int cyc);
      exp_t              e;
      bit                got_d;
      bit                seen;
      logic [LINE_W-1:0] wl;
      cyc  = 0;
      seen = 1'b0;
      got_d = 1'b0;
      while (!seen && cyc <= BUDGET) begin
         tick();
         cyc++;
         if (i_dfp_resp || d_dfp_resp) begin
            seen  = 1'b1;
            got_d = d_dfp_resp;
         end
      end
      if (!seen) begin
         vectors++;
         assert (cyc <= BUDGET) else begin
            miscompares++;
            $error("FAIL %s_timeout observed=%0d cycles expected<=%0d", tag, cyc, BUDGET);
         end
         cyc = -1;
         return;
      end
      e = exp_q.pop_front();
      check({tag, "_port"}, LINE_W'(got_d), LINE_W'(e.kind != 0));
      if (e.kind == 2) begin
         wl = '0;
         for (int k = 0; k < wq.size() && k < BEATS; k++) wl[DATA_W*k +: DATA_W] = wq[k];
         check({tag, "_wbeats"}, LINE_W'(wq.size()), LINE_W'(BEATS));
         check({tag, "_wdata"}, wl, e.line);
      end else begin
         check({tag, "_rdata"}, got_d ? d_dfp_rdata : i_dfp_rdata, e.line);
      end
      case (e.kind)
         0:       i_dfp_read  = 1'b0;
         1:       d_dfp_read  = 1'b0;
         default: d_dfp_write = 1'b0;
      endcase
      tick();
      check({tag, "_pulse"}, LINE_W'({i_dfp_resp, d_dfp_resp}), '0);
   endtask

   initial begin
      int                cyc;
      int                cnt0;
      int                hi;
      logic [LINE_W-1:0] wline;

      rst = 1'b1;
      i_dfp_addr = '0; i_dfp_read = 1'b0;
      d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
      bmem_ready = 1'b1;
      tick(); tick();
      check("rst_read",  LINE_W'(bmem_read), '0);
      check("rst_write", LINE_W'(bmem_write), '0);
      check("rst_addr",  LINE_W'(bmem_addr), '0);
      check("rst_wdata", LINE_W'(bmem_wdata), '0);
      check("rst_resp",  LINE_W'({i_dfp_resp, d_dfp_resp}), '0);
      check("rst_rdata", i_dfp_rdata | d_dfp_rdata, '0);
      rst = 1'b0;
      tick();

      // I-cache read alone, unaligned address, beats A..D.
      beat_base = 64'hA; addr_tag = 1'b0;
      cnt0 = rd_cmds; rd_hi = 0;
      exp_q.push_back('{kind: 0, line: {64'hD, 64'hC, 64'hB, 64'hA}});
      i_dfp_addr = 32'h1234_5678; i_dfp_read = 1'b1;
      finish_txn("i_rd", cyc);
      check("i_rd_cmds", LINE_W'(rd_cmds - cnt0), LINE_W'(1));
      check("i_rd_addr", LINE_W'(cmd_addr), LINE_W'(32'h1234_5660));
      check("i_rd_pulse_len", LINE_W'(rd_hi), LINE_W'(1));

      // D-cache writeback; resp on the 6th cycle counting the request cycle.
      wline = {64'h4, 64'h3, 64'h2, 64'h1};
      wq.delete();
      exp_q.push_back('{kind: 2, line: wline});
      d_dfp_addr = 32'h0000_1000; d_dfp_wdata = wline; d_dfp_write = 1'b1;
      finish_txn("d_wr", cyc);
      check("d_wr_latency", LINE_W'(cyc), LINE_W'(5));
      check("d_wr_addr", LINE_W'(wr_addr), LINE_W'(32'h0000_1000));

      // Simultaneous reads after reset: I first, then D.
      rst = 1'b1; tick(); rst = 1'b0; tick();
      addr_tag = 1'b1; beat_base = 64'h100;
      exp_q.push_back('{kind: 0, line: mk_line(32'h0000_0100)});
      exp_q.push_back('{kind: 1, line: mk_line(32'h0000_0200)});
      i_dfp_addr = 32'h0000_0100; i_dfp_read = 1'b1;
      d_dfp_addr = 32'h0000_0200; d_dfp_read = 1'b1;
      finish_txn("tie1_first", cyc);
      finish_txn("tie1_second", cyc);

      // I-only read leaves I as last winner, so the next tie goes to D.
      exp_q.push_back('{kind: 0, line: mk_line(32'h0000_0300)});
      i_dfp_addr = 32'h0000_0300; i_dfp_read = 1'b1;
      finish_txn("i_only", cyc);
      exp_q.push_back('{kind: 1, line: mk_line(32'h0000_0220)});
      exp_q.push_back('{kind: 0, line: mk_line(32'h0000_0120)});
      i_dfp_addr = 32'h0000_0120; i_dfp_read = 1'b1;
      d_dfp_addr = 32'h0000_0220; d_dfp_read = 1'b1;
      finish_txn("tie2_first", cyc);
      finish_txn("tie2_second", cyc);

      // D read+write together: write burst first, then the refill.
      wline = {64'h8888, 64'h7777, 64'h6666, 64'h5555};
      wq.delete();
      cnt0 = rd_cmds;
      exp_q.push_back('{kind: 2, line: wline});
      exp_q.push_back('{kind: 1, line: mk_line(32'h0000_3000)});
      d_dfp_addr = 32'h0000_3004; d_dfp_wdata = wline;
      d_dfp_read = 1'b1; d_dfp_write = 1'b1;
      finish_txn("rw_write", cyc);
      check("rw_no_rd_yet", LINE_W'(rd_cmds - cnt0), '0);
      finish_txn("rw_read", cyc);
      check("rw_rd_cmds", LINE_W'(rd_cmds - cnt0), LINE_W'(1));

      // Ready held low: read command stays up; then stray and foreign beats.
      bmem_ready = 1'b0;
      cnt0 = rd_cmds;
      inject_bad = 1'b1;
      exp_q.push_back('{kind: 0, line: mk_line(32'h0000_4000)});
      i_dfp_addr = 32'h0000_4010; i_dfp_read = 1'b1;
      hi = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bmem_read) hi++;
      end
      check("stall_read_held", LINE_W'(hi), LINE_W'(5));
      check("stall_no_cmd", LINE_W'(rd_cmds - cnt0), '0);
      bmem_ready = 1'b1;
      finish_txn("stall_rd", cyc);
      inject_bad = 1'b0;

      // Reset during write beat 2.
      wq.delete();
      d_dfp_addr = 32'h0000_5000; d_dfp_wdata = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
      d_dfp_write = 1'b1;
      tick(); tick(); tick();
      check("mid_wr_beat2", LINE_W'(bmem_wdata), LINE_W'(64'hC3));
      check("mid_wr_count", LINE_W'(wq.size()), LINE_W'(2));
      #1;
      rst = 1'b1; d_dfp_write = 1'b0;
      #1;
      check("arst_write", LINE_W'(bmem_write), '0);
      check("arst_wdata", LINE_W'(bmem_wdata), '0);
      check("arst_addr",  LINE_W'(bmem_addr), '0);
      check("arst_rdata", i_dfp_rdata | d_dfp_rdata, '0);
      tick(); rst = 1'b0; tick();
      check("post_rst_idle", LINE_W'({bmem_read, bmem_write, d_dfp_resp}), '0);
      exp_q.push_back('{kind: 0, line: mk_line(32'h0000_6000)});
      i_dfp_addr = 32'h0000_6000; i_dfp_read = 1'b1;
      finish_txn("post_rst_rd", cyc);
      check("scoreboard_empty", LINE_W'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
